// File: rtl/route_dispatch_mc.sv
// Multicast dispatcher: buffers tagged words, fans each out to its routed and enabled channels, lowest channel first.
// Latency: 2 cycles from dv_in to dv_out when idle; one instruction per cycle, no bubble between words.
// Backpressure: rdy_in low holds dv_out/chan_out/src_out/data_out; FIFO overflow drops the word and bumps a saturating counter.
module route_dispatch_mc #(
    parameter int W_SRC      = 5,
    parameter int N_SRC      = 32,
    parameter int W_CHAN     = 5,
    parameter int N_CHAN     = 8,
    parameter int W_DATA     = 18,
    parameter int W_DEPTH    = 4,
    parameter int W_WR_ADDR  = 16,
    parameter int W_WR_CHAN  = 16,
    parameter int W_WR_DATA  = 48,
    parameter int ADDR_ROUTE = 1,
    parameter int ADDR_EN    = 2,
    parameter int W_OVF      = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 dv_in,
    input  logic [W_SRC-1:0]     src_in,
    input  logic [W_DATA-1:0]    data_in,
    input  logic                 wr_en,
    input  logic [W_WR_ADDR-1:0] wr_addr,
    input  logic [W_WR_CHAN-1:0] wr_chan,
    input  logic [W_WR_DATA-1:0] wr_data,
    input  logic                 rdy_in,
    output logic                 dv_out,
    output logic [W_CHAN-1:0]    chan_out,
    output logic [W_SRC-1:0]     src_out,
    output logic [W_DATA-1:0]    data_out,
    output logic                 fifo_full_out,
    output logic [W_OVF-1:0]     ovf_count_out
);

    localparam int DEPTH  = 1 << W_DEPTH;
    localparam int W_WORD = W_SRC + W_DATA;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [W_WORD-1:0]  mem [DEPTH];
    logic [W_DEPTH-1:0] wr_ptr;
    logic [W_DEPTH-1:0] rd_ptr;
    logic [W_DEPTH:0]   count;
    logic [W_DEPTH:0]   count_next;

    logic [N_CHAN-1:0]  route [N_SRC];
    logic [N_CHAN-1:0]  en;

    logic [0:0]         state;
    logic [N_CHAN-1:0]  pending;
    logic [N_CHAN-1:0]  pending_rest;
    logic [N_CHAN-1:0]  route_sel;
    logic [N_CHAN-1:0]  head_pending;
    logic [W_WORD-1:0]  head;
    logic [W_SRC-1:0]   head_src;
    logic [W_DATA-1:0]  head_data;

    logic fifo_empty;
    logic fifo_full;
    logic hs;
    logic word_done;
    logic pop;
    logic push_ok;
    logic drop;
    logic unused_wr_data;

    assign unused_wr_data = ^wr_data[W_WR_DATA-1:N_CHAN];

    function automatic logic [W_CHAN-1:0] lowest_bit(input logic [N_CHAN-1:0] m);
        logic [W_CHAN-1:0] idx;
        idx = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (m[i]) idx = W_CHAN'(i);
        end
        return idx;
    endfunction

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == (W_DEPTH+1)'(DEPTH));
    assign hs           = (state == ST_SEND) && rdy_in;
    assign pending_rest = pending & (pending - N_CHAN'(1));
    assign word_done    = hs && (pending_rest == '0);
    assign pop          = !fifo_empty && ((state == ST_IDLE) || word_done);
    assign push_ok      = dv_in && (!fifo_full || pop);
    assign drop         = dv_in && fifo_full && !pop;
    assign count_next   = count + (W_DEPTH+1)'(push_ok) - (W_DEPTH+1)'(pop);

    assign head      = mem[rd_ptr];
    assign head_src  = head[W_WORD-1:W_DATA];
    assign head_data = head[W_DATA-1:0];

    // Sources without a table entry select nothing, so their words are discarded.
    always_comb begin
        route_sel = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (head_src == W_SRC'(s)) route_sel = route[s];
        end
    end

    assign head_pending = route_sel & en;

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr] <= {src_in, data_in};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_full_out <= 1'b0;
            ovf_count_out <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + W_DEPTH'(1);
            if (pop)     rd_ptr <= rd_ptr + W_DEPTH'(1);
            count         <= count_next;
            fifo_full_out <= (count_next == (W_DEPTH+1)'(DEPTH));
            if (drop && (ovf_count_out != {W_OVF{1'b1}})) ovf_count_out <= ovf_count_out + W_OVF'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < N_SRC; s++) route[s] <= '0;
            en <= '0;
        end else if (wr_en) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (wr_addr == W_WR_ADDR'(ADDR_ROUTE) && wr_chan == W_WR_CHAN'(s))
                    route[s] <= wr_data[N_CHAN-1:0];
            end
            for (int c = 0; c < N_CHAN; c++) begin
                if (wr_addr == W_WR_ADDR'(ADDR_EN) && wr_chan == W_WR_CHAN'(c))
                    en[c] <= wr_data[0];
            end
        end
    end

    // The channel set is snapshotted at pop; later config writes only affect later words.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            pending  <= '0;
            dv_out   <= 1'b0;
            chan_out <= '0;
            src_out  <= '0;
            data_out <= '0;
        end else if (pop) begin
            src_out  <= head_src;
            data_out <= head_data;
            pending  <= head_pending;
            if (head_pending != '0) begin
                state    <= ST_SEND;
                dv_out   <= 1'b1;
                chan_out <= lowest_bit(head_pending);
            end else begin
                state    <= ST_IDLE;
                dv_out   <= 1'b0;
                chan_out <= '0;
            end
        end else if (hs) begin
            if (pending_rest != '0) begin
                pending  <= pending_rest;
                chan_out <= lowest_bit(pending_rest);
            end else begin
                state    <= ST_IDLE;
                pending  <= '0;
                dv_out   <= 1'b0;
                chan_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_route_dispatch_mc.sv
// Bench for route_dispatch_mc: vector table, directed corner sequences, and a randomized run against a queue model.
module tb_route_dispatch_mc;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        dv_in = 1'b0;
    logic [4:0]  src_in = '0;
    logic [17:0] data_in = '0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_chan = '0;
    logic [47:0] wr_data = '0;
    logic        rdy_in = 1'b0;

    logic        dv_out;
    logic [4:0]  chan_out;
    logic [4:0]  src_out;
    logic [17:0] data_out;
    logic        fifo_full_out;
    logic [15:0] ovf_count_out;

    logic        s_dv;
    logic [4:0]  s_chan;
    logic [4:0]  s_src;
    logic [17:0] s_data;
    logic        s_full;
    logic [2:0]  s_ovf;

    always #5 clk_in = ~clk_in;

    route_dispatch_mc dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dv_in(dv_in), .src_in(src_in), .data_in(data_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data), .rdy_in(rdy_in),
        .dv_out(dv_out), .chan_out(chan_out), .src_out(src_out), .data_out(data_out),
        .fifo_full_out(fifo_full_out), .ovf_count_out(ovf_count_out)
    );

    // Shallow FIFO and narrow counter so saturation is reachable in a few cycles.
    route_dispatch_mc #(.W_DEPTH(3), .W_OVF(3)) dut_small (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dv_in(dv_in), .src_in(src_in), .data_in(data_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data), .rdy_in(rdy_in),
        .dv_out(s_dv), .chan_out(s_chan), .src_out(s_src), .data_out(s_data),
        .fifo_full_out(s_full), .ovf_count_out(s_ovf)
    );

    typedef struct {
        logic [7:0]  route;
        logic [7:0]  en;
        logic [4:0]  src;
        logic [17:0] data;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [4:0]  chan;
        logic [4:0]  src;
        logic [17:0] data;
        bit          last;
    } ins_t;

    vec_t vecs[6];
    ins_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic cfg(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_en(input logic [7:0] m);
        for (int i = 0; i < 8; i++) cfg(16'd2, 16'(i), 48'(m[i]));
    endtask

    task automatic drive_word(input logic [4:0] s, input logic [17:0] d);
        dv_in = 1'b1; src_in = s; data_in = d;
    endtask

    logic [7:0]  route_m [32];
    logic [7:0]  en_m;
    logic        prev_stall;
    logic [27:0] prev_out;
    int          inflight;
    int          chs[3];

    task automatic rand_cycle(input bit drain);
        logic [7:0] mask;
        int hi;
        ins_t e;
        if (prev_stall) chk("stall_hold", {dv_out, chan_out, src_out, data_out}, {1'b1, prev_out});
        rdy_in = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        dv_in = 1'b0;
        if (!drain && inflight < 15 && $urandom_range(0, 1) == 1) begin
            drive_word(5'($urandom_range(0, 31)), 18'($urandom));
            mask = route_m[src_in] & en_m;
            hi = -1;
            for (int c = 0; c < 8; c++) if (mask[c]) hi = c;
            for (int c = 0; c < 8; c++) begin
                if (mask[c]) begin
                    e.chan = 5'(c); e.src = src_in; e.data = data_in; e.last = (c == hi);
                    exp_q.push_back(e);
                end
            end
            inflight++;
        end
        if (dv_out && rdy_in) begin
            if (exp_q.size() == 0) begin
                chk("no_extra_ins", dv_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_ins", {chan_out, src_out, data_out}, {e.chan, e.src, e.data});
                if (e.last) inflight--;
            end
        end
        prev_stall = dv_out && !rdy_in;
        prev_out   = {chan_out, src_out, data_out};
        step();
    endtask

    initial begin
        vecs[0] = '{8'hA1, 8'hFF, 5'd3,  18'h155,   8'hA1};
        vecs[1] = '{8'hA1, 8'hDF, 5'd3,  18'h2AAAA, 8'h81};
        vecs[2] = '{8'h00, 8'hFF, 5'd9,  18'h00001, 8'h00};
        vecs[3] = '{8'hFF, 8'h0F, 5'd31, 18'h3FFFF, 8'h0F};
        vecs[4] = '{8'h80, 8'hFF, 5'd0,  18'h00000, 8'h80};
        vecs[5] = '{8'h3C, 8'h55, 5'd17, 18'h12345, 8'h14};
        chs = '{0, 5, 7};

        step(); step();
        chk("reset_outputs", {dv_out, chan_out, src_out, data_out, fifo_full_out, ovf_count_out}, 64'd0);
        rst_n_in = 1'b1;
        step();

        // Single-word vectors with rdy_in held high.
        rdy_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cfg(16'd1, 16'(vecs[k].src), 48'(vecs[k].route));
            set_en(vecs[k].en);
            drive_word(vecs[k].src, vecs[k].data);
            step();
            dv_in = 1'b0;
            chk($sformatf("vec%0d_latency", k), dv_out, 1'b0);
            for (int c = 0; c < 8; c++) begin
                if (vecs[k].exp[c]) begin
                    step();
                    chk($sformatf("vec%0d_ch%0d", k, c), {dv_out, chan_out, src_out, data_out},
                        {1'b1, 5'(c), vecs[k].src, vecs[k].data});
                end
            end
            step();
            chk($sformatf("vec%0d_end", k), {dv_out, chan_out}, 6'd0);
        end

        // Stall for four cycles on the first channel.
        cfg(16'd1, 16'd3, 48'hA1);
        set_en(8'hFF);
        rdy_in = 1'b0;
        drive_word(5'd3, 18'h155);
        step();
        dv_in = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_ch0", {dv_out, chan_out, data_out}, {1'b1, 5'd0, 18'h155});
            step();
        end
        rdy_in = 1'b1;
        step(); chk("stall_ch5", {dv_out, chan_out, data_out}, {1'b1, 5'd5, 18'h155});
        step(); chk("stall_ch7", {dv_out, chan_out, data_out}, {1'b1, 5'd7, 18'h155});
        step(); chk("stall_end", dv_out, 1'b0);

        // Config writes during SEND must not touch the in-flight word.
        rdy_in = 1'b0;
        drive_word(5'd3, 18'h0BEEF);
        step();
        dv_in = 1'b0;
        step();
        cfg(16'd1, 16'd3, 48'h0);
        cfg(16'd2, 16'd7, 48'h0);
        rdy_in = 1'b1;
        step(); chk("snap_ch5", {dv_out, chan_out}, {1'b1, 5'd5});
        step(); chk("snap_ch7", {dv_out, chan_out, data_out}, {1'b1, 5'd7, 18'h0BEEF});
        step(); chk("snap_end", dv_out, 1'b0);
        cfg(16'd1, 16'd3, 48'hA1);
        cfg(16'd2, 16'd7, 48'h1);

        // Back-to-back words with no bubble.
        cfg(16'd1, 16'd4, 48'h04);
        drive_word(5'd3, 18'h00111);
        step();
        drive_word(5'd4, 18'h00222);
        step();
        dv_in = 1'b0;
        chk("b2b_0", {dv_out, chan_out, src_out}, {1'b1, 5'd0, 5'd3});
        step(); chk("b2b_5", {dv_out, chan_out}, {1'b1, 5'd5});
        step(); chk("b2b_7", {dv_out, chan_out}, {1'b1, 5'd7});
        step(); chk("b2b_2", {dv_out, chan_out, src_out, data_out}, {1'b1, 5'd2, 5'd4, 18'h00222});
        step(); chk("b2b_end", dv_out, 1'b0);

        // Fill: one word parks in the output stage, 16 fill the FIFO, 3 are dropped.
        rdy_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_word(5'd3, 18'(i));
            step();
        end
        dv_in = 1'b0;
        chk("ovf_full", fifo_full_out, 1'b1);
        chk("ovf_count", ovf_count_out, 16'd3);
        chk("ovf_small_sat", s_ovf, 3'd7);
        chk("ovf_small_full", s_full, 1'b1);
        rdy_in = 1'b1;
        for (int w = 0; w < 17; w++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("drain_w%0d_c%0d", w, chs[j]), {dv_out, chan_out, data_out},
                    {1'b1, 5'(chs[j]), 18'(w)});
                step();
            end
        end
        chk("drain_end", {dv_out, fifo_full_out, ovf_count_out}, {1'b0, 1'b0, 16'd3});

        // Out-of-range config indices and foreign addresses are ignored.
        cfg(16'd1, 16'd0, 48'h01);
        cfg(16'd2, 16'd8, 48'h0);
        cfg(16'd1, 16'd32, 48'h0);
        cfg(16'd3, 16'd0, 48'h0);
        cfg(16'h0101, 16'd0, 48'h0);
        drive_word(5'd0, 18'h3ABCD);
        step();
        dv_in = 1'b0;
        step(); chk("cfg_ignore", {dv_out, chan_out, data_out}, {1'b1, 5'd0, 18'h3ABCD});
        step(); chk("cfg_ignore_end", dv_out, 1'b0);

        // Asynchronous reset while stalled mid-word with more words queued.
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_word(5'd3, 18'(100 + i));
            step();
        end
        dv_in = 1'b0;
        step();
        chk("pre_reset_send", dv_out, 1'b1);
        #2 rst_n_in = 1'b0;
        #1 chk("async_reset", {dv_out, chan_out, src_out, data_out, fifo_full_out, ovf_count_out}, 64'd0);
        step();
        rst_n_in = 1'b1;
        rdy_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_reset_quiet", dv_out, 1'b0);
        end
        drive_word(5'd3, 18'h155);
        step();
        dv_in = 1'b0;
        step(); step();
        chk("post_reset_cfg_clear", dv_out, 1'b0);

        // Randomized traffic against the queue model.
        for (int s = 0; s < 32; s++) begin
            route_m[s] = 8'($urandom_range(1, 255));
            cfg(16'd1, 16'(s), 48'(route_m[s]));
        end
        en_m = ~(8'(1) << $urandom_range(0, 7));
        set_en(en_m);
        prev_stall = 1'b0;
        prev_out   = '0;
        inflight   = 0;
        for (int cyc = 0; cyc < 1500; cyc++) rand_cycle(1'b0);
        for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) rand_cycle(1'b1);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_no_drop", ovf_count_out, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/route_dispatch_mc.md
Name: route_dispatch_mc

Overview:
Parametrised multicast instruction dispatcher that sits between the ADC input mux and the PID pipeline. Each tagged data word is buffered in an internal circular FIFO. The word's source selects a per-source output-channel route bitmap, which is ANDed with the channel-enable mask. One instruction is issued per enabled routed channel, lowest channel first. Output uses a valid/ready handshake, so the downstream pipeline can stall. Input overflow is counted, not silent.

Parameters:
W_SRC, 5, source tag width
N_SRC, 32, number of sources (route table depth), <= 2^W_SRC
W_CHAN, 5, output channel index width
N_CHAN, 8, number of PID channels, <= 2^W_CHAN and <= W_WR_DATA
W_DATA, 18, data word width
W_DEPTH, 4, log2 FIFO depth (16 entries)
W_WR_ADDR, 16, config address width
W_WR_CHAN, 16, config channel/index width
W_WR_DATA, 48, config data width
ADDR_ROUTE, 1, config address of route table
ADDR_EN, 2, config address of channel enable
W_OVF, 16, overflow counter width

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset, asynchronous, active-low
dv_in  in  1  input word valid
src_in  in  W_SRC  input source tag
data_in  in  W_DATA  input data
wr_en  in  1  config write strobe
wr_addr  in  W_WR_ADDR  config address
wr_chan  in  W_WR_CHAN  config index (source for ROUTE, channel for EN)
wr_data  in  W_WR_DATA  config data
rdy_in  in  1  downstream ready
dv_out  out  1  instruction valid
chan_out  out  W_CHAN  destination channel
src_out  out  W_SRC  source of current word
data_out  out  W_DATA  data of current word
fifo_full_out  out  1  FIFO holds 2^W_DEPTH entries
ovf_count_out  out  W_OVF  dropped-word count, saturating

Behaviour:
- One clock domain: clk_in. Async active-low reset rst_n_in clears all state:
  - FIFO pointers and count to 0; route table and enable mask to 0.
  - FSM to IDLE; pending mask to 0.
  - dv_out, chan_out, src_out, data_out, ovf_count_out, fifo_full_out all to 0.
- Config writes take effect at the edge where wr_en=1:
  - ADDR_ROUTE: route[wr_chan] <= wr_data[N_CHAN-1:0]. Ignored if wr_chan >= N_SRC.
  - ADDR_EN: en[wr_chan] <= wr_data[0]. Ignored if wr_chan >= N_CHAN.
  - Any other address is ignored.
- FIFO push: dv_in=1 pushes {src_in,data_in}.
  - If full and no pop occurs at the same edge, the word is dropped and ovf_count increments, saturating at all-ones.
  - If full and a pop occurs at the same edge, the push is accepted.
  - fifo_full_out is registered and reflects the post-edge count.
- Pop rule:
  - Pop occurs at the edge where state is IDLE and the FIFO is non-empty.
  - Pop also occurs at the edge completing the last handshake of a word while the FIFO is non-empty (back-to-back).
  - On pop, register src/data and snapshot pending = route[src] & en, using table values before any same-edge config write.
  - If src >= N_SRC, pending = 0.
  - If the popped pending = 0, the word is discarded: state goes (or stays) IDLE, dv_out=0, and one cycle is consumed.
  - If the popped pending != 0, go to SEND.
- SEND state:
  - dv_out=1, chan_out = index of lowest set bit of pending; src_out and data_out hold the word.
  - Outputs are stable while dv_out=1 and rdy_in=0.
  - A handshake is dv_out & rdy_in at an edge; it clears that pending bit.
  - If pending bits remain, chan_out moves to the next lowest set bit and the state stays SEND.
  - If none remain: pop the next word if the FIFO is non-empty, else go to IDLE with dv_out=0.
- Throughput: one instruction per cycle with rdy_in=1, with no bubble between words.
- Latency from idle: dv_in sampled at edge E0, popped at E1, dv_out=1 during the cycle after E1 (2 cycles).
- Config changes during SEND do not alter the current word's snapshot.
- chan_out is 0 when dv_out=0. src_out and data_out hold their last values.
- Reset asserted mid-SEND drops the in-flight word and all queued words.

Test Plan:
- Reset, then route[3]=8'b1010_0001, en=all ones; dv_in src=3 data=18'h155, rdy_in=1 -> dv_out high 2 cycles after dv_in for 3 consecutive cycles, chan_out=0,5,7, data_out=18'h155; then dv_out=0.
- Same setup with rdy_in=0 for 4 cycles then 1 -> chan_out held at 0 and data stable while stalled; then 0,5,7 over 3 cycles; no instruction lost or duplicated.
- en[5]=0 (wr_addr=2, wr_chan=5, wr_data=0), repeat word -> only chan 0 and 7 issued. Word with route=0 -> no dv_out, next word still dispatched.
- rdy_in=0, 16 words into FIFO, then 3 more dv_in -> fifo_full_out=1, ovf_count_out=3. Then 16 words drain in order; ovf counter saturates at 16'hFFFF when forced.
- Two back-to-back words (src 3, src 4 routed to chan 2), rdy_in=1 -> chans 0,5,7,2 in 4 consecutive cycles, no bubble.
- rst_n_in pulsed low mid-SEND -> dv_out=0 immediately (async); after release, no stale instructions issued and config reads back as disabled.
